// File: rtl/reg_file_mp.sv
// Parametrised dual-read register file with registered reads and a per-register
// busy scoreboard. Optional macro RF_BYPASS_EN enables same-cycle write-to-read forwarding.
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2,
    output logic                  BUSY_R1,
    output logic                  BUSY_R2,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    input  logic                  RESERVE,
    input  logic [ADDR_WIDTH-1:0] ADDR_RSV,
    output logic                  BUSY_ANY
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      r_busy;
    logic [DATA_WIDTH-1:0] r_data_r1;
    logic [DATA_WIDTH-1:0] r_data_r2;
    logic                  r_busy_r1;
    logic                  r_busy_r2;

    logic                  w_zero_w;
    logic                  w_zero_rsv;
    logic                  w_zero_r1;
    logic                  w_zero_r2;
    logic                  w_wr_en;
    logic                  w_rsv_en;
    logic [DEPTH-1:0]      w_busy_nxt;
    logic [DATA_WIDTH-1:0] w_rd1_data;
    logic [DATA_WIDTH-1:0] w_rd2_data;
    logic                  w_rd1_busy;
    logic                  w_rd2_busy;

    // Register 0 is hardwired only when ZERO_REG is set.
    assign w_zero_w   = (ZERO_REG != 0) && (ADDR_W   == '0);
    assign w_zero_rsv = (ZERO_REG != 0) && (ADDR_RSV == '0);
    assign w_zero_r1  = (ZERO_REG != 0) && (ADDR_R1  == '0);
    assign w_zero_r2  = (ZERO_REG != 0) && (ADDR_R2  == '0);

    assign w_wr_en  = WRITE   && !w_zero_w;
    assign w_rsv_en = RESERVE && !w_zero_rsv;

    // Reserve is applied after the write-back clear so a new producer wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_en) begin
            w_busy_nxt[ADDR_W] = 1'b0;
        end
        if (w_rsv_en) begin
            w_busy_nxt[ADDR_RSV] = 1'b1;
        end
    end

    always_comb begin
        w_rd1_data = r_mem[ADDR_R1];
        w_rd1_busy = r_busy[ADDR_R1];
        w_rd2_data = r_mem[ADDR_R2];
        w_rd2_busy = r_busy[ADDR_R2];
`ifdef RF_BYPASS_EN
        if (w_wr_en && (ADDR_W == ADDR_R1)) begin
            w_rd1_data = DATA_W;
            w_rd1_busy = w_busy_nxt[ADDR_R1];
        end
        if (w_wr_en && (ADDR_W == ADDR_R2)) begin
            w_rd2_data = DATA_W;
            w_rd2_busy = w_busy_nxt[ADDR_R2];
        end
`endif
        if (w_zero_r1) begin
            w_rd1_data = '0;
            w_rd1_busy = 1'b0;
        end
        if (w_zero_r2) begin
            w_rd2_data = '0;
            w_rd2_busy = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[ADDR_W] <= DATA_W;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_data_r1 <= '0;
            r_data_r2 <= '0;
            r_busy_r1 <= 1'b0;
            r_busy_r2 <= 1'b0;
        end else if (READ) begin
            r_data_r1 <= w_rd1_data;
            r_data_r2 <= w_rd2_data;
            r_busy_r1 <= w_rd1_busy;
            r_busy_r2 <= w_rd2_busy;
        end
    end

    assign DATA_R1  = r_data_r1;
    assign DATA_R2  = r_data_r2;
    assign BUSY_R1  = r_busy_r1;
    assign BUSY_R2  = r_busy_r2;
    assign BUSY_ANY = |r_busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default 32x32 instance plus a 16-bit x 8 instance.
module tb_reg_file_mp;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;

    logic        a_read = 1'b0, a_write = 1'b0, a_reserve = 1'b0;
    logic [4:0]  a_addr_r1 = '0, a_addr_r2 = '0, a_addr_w = '0, a_addr_rsv = '0;
    logic [31:0] a_data_w = '0;
    logic [31:0] a_data_r1, a_data_r2;
    logic        a_busy_r1, a_busy_r2, a_busy_any;

    logic        b_read = 1'b0, b_write = 1'b0, b_reserve = 1'b0;
    logic [2:0]  b_addr_r1 = '0, b_addr_r2 = '0, b_addr_w = '0, b_addr_rsv = '0;
    logic [15:0] b_data_w = '0;
    logic [15:0] b_data_r1, b_data_r2;
    logic        b_busy_r1, b_busy_r2, b_busy_any;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    reg_file_mp u_dut_a (
        .CLK(CLK), .RST(RST), .READ(a_read),
        .ADDR_R1(a_addr_r1), .ADDR_R2(a_addr_r2),
        .DATA_R1(a_data_r1), .DATA_R2(a_data_r2),
        .BUSY_R1(a_busy_r1), .BUSY_R2(a_busy_r2),
        .WRITE(a_write), .ADDR_W(a_addr_w), .DATA_W(a_data_w),
        .RESERVE(a_reserve), .ADDR_RSV(a_addr_rsv), .BUSY_ANY(a_busy_any)
    );

    reg_file_mp #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1)) u_dut_b (
        .CLK(CLK), .RST(RST), .READ(b_read),
        .ADDR_R1(b_addr_r1), .ADDR_R2(b_addr_r2),
        .DATA_R1(b_data_r1), .DATA_R2(b_data_r2),
        .BUSY_R1(b_busy_r1), .BUSY_R2(b_busy_r2),
        .WRITE(b_write), .ADDR_W(b_addr_w), .DATA_W(b_data_w),
        .RESERVE(b_reserve), .ADDR_RSV(b_addr_rsv), .BUSY_ANY(b_busy_any)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
        a_read = 1'b0; a_write = 1'b0; a_reserve = 1'b0;
        b_read = 1'b0; b_write = 1'b0; b_reserve = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (a_data_r1 !== 32'h0 || a_data_r2 !== 32'h0) begin
            errors++; $display("FAIL reset_data got %h/%h exp 0/0", a_data_r1, a_data_r2);
        end
        checks++;
        if (a_busy_r1 !== 1'b0 || a_busy_r2 !== 1'b0 || a_busy_any !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b%b%b exp 000", a_busy_r1, a_busy_r2, a_busy_any);
        end
        #1 RST = 1'b1;
        @(posedge CLK); #1;

        a_write = 1'b1; a_addr_w = 5'd4; a_data_w = 32'h0000CAFE;
        tick();
        a_reserve = 1'b1; a_addr_rsv = 5'd6;
        tick();
        a_read = 1'b1; a_addr_r1 = 5'd4; a_addr_r2 = 5'd6;
        tick();
        checks++;
        if (a_data_r1 !== 32'h0000CAFE || a_busy_r2 !== 1'b1 || a_busy_any !== 1'b1) begin
            errors++; $display("FAIL prereset_state got %h %b %b exp 0000cafe 1 1", a_data_r1, a_busy_r2, a_busy_any);
        end

        // Mid-cycle async reset, with a write pending on the inputs.
        #2;
        a_write = 1'b1; a_addr_w = 5'd8; a_data_w = 32'h12345678;
        RST = 1'b0;
        #1;
        checks++;
        if (a_data_r1 !== 32'h0 || a_data_r2 !== 32'h0) begin
            errors++; $display("FAIL async_reset_data got %h/%h exp 0/0", a_data_r1, a_data_r2);
        end
        checks++;
        if (a_busy_r2 !== 1'b0 || a_busy_any !== 1'b0) begin
            errors++; $display("FAIL async_reset_busy got %b %b exp 0 0", a_busy_r2, a_busy_any);
        end
        a_write = 1'b0;
        #2 RST = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 32; i++) begin
            a_read = 1'b1; a_addr_r1 = 5'(i); a_addr_r2 = 5'(31 - i);
            tick();
            checks++;
            if (a_data_r1 !== 32'h0 || a_data_r2 !== 32'h0 || a_busy_r1 !== 1'b0) begin
                errors++; $display("FAIL post_reset_read[%0d] got %h/%h busy %b exp 0/0 busy 0", i, a_data_r1, a_data_r2, a_busy_r1);
            end
        end
        checks++;
        if (a_busy_any !== 1'b0) begin
            errors++; $display("FAIL post_reset_busy_any got %b exp 0", a_busy_any);
        end
    endtask

    task automatic test_zero_reg();
        a_write = 1'b1; a_addr_w = 5'd5; a_data_w = 32'hDEADBEEF;
        tick();
        a_read = 1'b1; a_addr_r1 = 5'd5; a_addr_r2 = 5'd0;
        tick();
        checks++;
        if (a_data_r1 !== 32'hDEADBEEF || a_data_r2 !== 32'h0) begin
            errors++; $display("FAIL read_r5_r0 got %h/%h exp deadbeef/00000000", a_data_r1, a_data_r2);
        end
        a_write = 1'b1; a_addr_w = 5'd0; a_data_w = 32'h00001234;
        tick();
        a_read = 1'b1; a_addr_r1 = 5'd0; a_addr_r2 = 5'd0;
        tick();
        checks++;
        if (a_data_r1 !== 32'h0 || a_data_r2 !== 32'h0) begin
            errors++; $display("FAIL zero_reg_write got %h/%h exp 0/0", a_data_r1, a_data_r2);
        end
        a_reserve = 1'b1; a_addr_rsv = 5'd0;
        tick();
        checks++;
        if (a_busy_any !== 1'b0) begin
            errors++; $display("FAIL zero_reg_reserve got busy_any %b exp 0", a_busy_any);
        end
    endtask

    task automatic test_scoreboard();
        a_reserve = 1'b1; a_addr_rsv = 5'd7;
        tick();
        checks++;
        if (a_busy_any !== 1'b1) begin
            errors++; $display("FAIL reserve_busy_any got %b exp 1", a_busy_any);
        end
        a_read = 1'b1; a_addr_r1 = 5'd7; a_addr_r2 = 5'd5;
        a_reserve = 1'b1; a_addr_rsv = 5'd7;
        tick();
        checks++;
        if (a_busy_r1 !== 1'b1 || a_busy_r2 !== 1'b0) begin
            errors++; $display("FAIL reserve_busy_r got %b%b exp 10", a_busy_r1, a_busy_r2);
        end
        a_write = 1'b1; a_addr_w = 5'd7; a_data_w = 32'h00000055;
        tick();
        checks++;
        if (a_busy_any !== 1'b0) begin
            errors++; $display("FAIL release_busy_any got %b exp 0", a_busy_any);
        end
        a_read = 1'b1; a_addr_r1 = 5'd7;
        tick();
        checks++;
        if (a_data_r1 !== 32'h00000055 || a_busy_r1 !== 1'b0) begin
            errors++; $display("FAIL release_read got %h busy %b exp 00000055 busy 0", a_data_r1, a_busy_r1);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_d;
        logic        exp_b;
        a_write = 1'b1; a_addr_w = 5'd9; a_data_w = 32'h00000011;
        tick();
        a_write = 1'b1; a_addr_w = 5'd9; a_data_w = 32'hA5A5A5A5;
        a_read = 1'b1; a_addr_r1 = 5'd9; a_addr_r2 = 5'd5;
        tick();
`ifdef RF_BYPASS_EN
        exp_d = 32'hA5A5A5A5;
`else
        exp_d = 32'h00000011;
`endif
        checks++;
        if (a_data_r1 !== exp_d || a_busy_r1 !== 1'b0 || a_data_r2 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rw_same_addr got %h busy %b r2 %h exp %h busy 0 r2 deadbeef", a_data_r1, a_busy_r1, a_data_r2, exp_d);
        end

        a_reserve = 1'b1; a_addr_rsv = 5'd9;
        tick();
        a_write = 1'b1; a_addr_w = 5'd9; a_data_w = 32'h00000022;
        a_read = 1'b1; a_addr_r1 = 5'd9; a_addr_r2 = 5'd9;
        tick();
`ifdef RF_BYPASS_EN
        exp_d = 32'h00000022; exp_b = 1'b0;
`else
        exp_d = 32'hA5A5A5A5; exp_b = 1'b1;
`endif
        checks++;
        if (a_data_r1 !== exp_d || a_data_r2 !== exp_d || a_busy_r1 !== exp_b || a_busy_r2 !== exp_b) begin
            errors++; $display("FAIL rw_release got %h/%h busy %b%b exp %h busy %b", a_data_r1, a_data_r2, a_busy_r1, a_busy_r2, exp_d, exp_b);
        end

        a_write = 1'b1; a_addr_w = 5'd10; a_data_w = 32'h00000033;
        a_reserve = 1'b1; a_addr_rsv = 5'd10;
        a_read = 1'b1; a_addr_r1 = 5'd10;
        tick();
`ifdef RF_BYPASS_EN
        exp_d = 32'h00000033; exp_b = 1'b1;
`else
        exp_d = 32'h00000000; exp_b = 1'b0;
`endif
        checks++;
        if (a_data_r1 !== exp_d || a_busy_r1 !== exp_b) begin
            errors++; $display("FAIL rw_reserve got %h busy %b exp %h busy %b", a_data_r1, a_busy_r1, exp_d, exp_b);
        end
        a_write = 1'b1; a_addr_w = 5'd10; a_data_w = 32'h00000033;
        tick();
        checks++;
        if (a_busy_any !== 1'b0) begin
            errors++; $display("FAIL bypass_cleanup got busy_any %b exp 0", a_busy_any);
        end
    endtask

    task automatic test_write_reserve();
        a_write = 1'b1; a_addr_w = 5'd3; a_data_w = 32'h00000077;
        a_reserve = 1'b1; a_addr_rsv = 5'd3;
        tick();
        checks++;
        if (a_busy_any !== 1'b1) begin
            errors++; $display("FAIL wr_rsv_busy_any got %b exp 1", a_busy_any);
        end
        a_read = 1'b1; a_addr_r1 = 5'd3; a_addr_r2 = 5'd3;
        tick();
        checks++;
        if (a_data_r1 !== 32'h77 || a_data_r2 !== 32'h77 || a_busy_r1 !== 1'b1 || a_busy_r2 !== 1'b1) begin
            errors++; $display("FAIL wr_rsv_read got %h/%h busy %b%b exp 77/77 busy 11", a_data_r1, a_data_r2, a_busy_r1, a_busy_r2);
        end
        for (int c = 0; c < 3; c++) begin
            a_write = 1'b1; a_addr_w = 5'd3; a_data_w = 32'h99 + 32'(c);
            a_addr_r1 = 5'd5; a_addr_r2 = 5'd9;
            tick();
            checks++;
            if (a_data_r1 !== 32'h77 || a_data_r2 !== 32'h77 || a_busy_r1 !== 1'b1 || a_busy_r2 !== 1'b1) begin
                errors++; $display("FAIL hold[%0d] got %h/%h busy %b%b exp 77/77 busy 11", c, a_data_r1, a_data_r2, a_busy_r1, a_busy_r2);
            end
        end
        checks++;
        if (a_busy_any !== 1'b0) begin
            errors++; $display("FAIL hold_busy_any got %b exp 0", a_busy_any);
        end
    endtask

    task automatic test_param();
        b_write = 1'b1; b_addr_w = 3'd7; b_data_w = 16'hFFFF;
        tick();
        b_write = 1'b1; b_addr_w = 3'd3; b_data_w = 16'h1234;
        b_read = 1'b1; b_addr_r1 = 3'd7; b_addr_r2 = 3'd7;
        tick();
        checks++;
        if (b_data_r1 !== 16'hFFFF || b_data_r2 !== 16'hFFFF) begin
            errors++; $display("FAIL narrow_same_addr got %h/%h exp ffff/ffff", b_data_r1, b_data_r2);
        end
        b_reserve = 1'b1; b_addr_rsv = 3'd3;
        b_read = 1'b1; b_addr_r1 = 3'd3; b_addr_r2 = 3'd0;
        tick();
        checks++;
        if (b_data_r1 !== 16'h1234 || b_data_r2 !== 16'h0 || b_busy_r1 !== 1'b0 || b_busy_any !== 1'b1) begin
            errors++; $display("FAIL narrow_read got %h/%h busy %b any %b exp 1234/0000 busy 0 any 1", b_data_r1, b_data_r2, b_busy_r1, b_busy_any);
        end
    endtask

    initial begin
        test_reset();
        test_zero_reg();
        test_scoreboard();
        test_bypass();
        test_write_reserve();
        test_param();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
